// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streaming block.
// Holds the output-buffer state encoding and the default widths.
package fifo_rd_stream_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } buf_state_e;

  // Number of words held for a given buffer state.
  function automatic logic [1:0] occ_of(buf_state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL2:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer: head/tail registers with an EMPTY/ONE/FULL2 state.
// Writes land at the tail, dequeues remove the head; both may happen together.
module fifo_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  r_rst_n,
  input  logic                  wr,
  input  logic [Data_Width-1:0] wr_data,
  input  logic                  deq,
  input  logic                  flush,
  output logic [Data_Width-1:0] head_data,
  output logic [1:0]            occupancy,
  output logic                  ovf
);

  buf_state_e            state, state_nxt;
  logic [Data_Width-1:0] head_q, head_nxt;
  logic [Data_Width-1:0] tail_q, tail_nxt;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_nxt = state;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    ovf       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (wr) begin
            state_nxt = ONE;
            head_nxt  = wr_data;
          end
        end
        ONE: begin
          if (wr && deq) begin
            head_nxt = wr_data;
          end else if (wr) begin
            state_nxt = FULL2;
            tail_nxt  = wr_data;
          end else if (deq) begin
            state_nxt = EMPTY;
          end
        end
        FULL2: begin
          if (deq) begin
            head_nxt = tail_q;
            if (wr) tail_nxt = wr_data;
            else    state_nxt = ONE;
          end else if (wr) begin
            ovf = 1'b1;  // no free slot: the incoming word is dropped
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the two data registers are reset too, so out_data reads 0 after
  // reset rather than stale contents.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state  <= state_nxt;
      head_q <= head_nxt;
      tail_q <= tail_nxt;
    end
  end

  assign head_data = head_q;
  assign occupancy = occ_of(state);

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a FIFO read port into a valid/ready stream through a 2-entry buffer,
// counting pops and flagging words that arrive with no free slot.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Cnt_Width  = CNT_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  r_rst_n,
  input  logic                  empty,
  input  logic [Data_Width-1:0] data_out,
  output logic                  r_en,
  input  logic                  rd_enable,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Data_Width-1:0] out_data,
  output logic [Cnt_Width-1:0]  pop_cnt,
  output logic                  ovf_err
);

  logic       inflight;
  logic       deq;
  logic       ovf;
  logic [1:0] occupancy;
  logic [1:0] occ_after;

  assign out_valid = (occupancy != 2'd0);
  assign deq       = out_valid && out_ready;
  assign occ_after = occupancy - {1'b0, deq};

  // Only pop when the word, once it lands, is guaranteed a slot; gated by
  // r_rst_n so no pop is requested while held in reset.
  assign r_en = r_rst_n && !empty && rd_enable && !flush
             && ((occ_after + {1'b0, inflight}) < 2'd2);

  fifo_skid_buf #(
    .Data_Width(Data_Width)
  ) u_buf (
    .rclk      (rclk),
    .r_rst_n   (r_rst_n),
    .wr        (inflight),
    .wr_data   (data_out),
    .deq       (deq),
    .flush     (flush),
    .head_data (out_data),
    .occupancy (occupancy),
    .ovf       (ovf)
  );

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      inflight <= 1'b0;
      pop_cnt  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      inflight <= r_en;  // r_en is already low during flush
      if (r_en) pop_cnt <= pop_cnt + 1'b1;
      if (ovf)  ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a small FIFO source model feeds the DUT,
// each scenario task checks hand-computed outputs cycle by cycle.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          r_rst_n;
  logic          empty;
  logic [DW-1:0] data_out = '0;
  logic          r_en;
  logic          rd_enable;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pop_cnt;
  logic          ovf_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  fifo_rd_stream #(.Data_Width(DW), .Cnt_Width(CW)) dut (
    .rclk      (rclk),
    .r_rst_n   (r_rst_n),
    .empty     (empty),
    .data_out  (data_out),
    .r_en      (r_en),
    .rd_enable (rd_enable),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pop_cnt   (pop_cnt),
    .ovf_err   (ovf_err)
  );

  always #5 rclk = ~rclk;

  // FIFO source: words appended by tests, popped on r_en, data valid next cycle.
  logic [DW-1:0] src [0:63];
  int   src_len = 0;
  int   rd_idx  = 0;
  logic r_en_s  = 1'b0;

  assign empty = (rd_idx >= src_len);

  always @(negedge rclk) r_en_s = r_en;

  always @(posedge rclk) begin
    if (r_rst_n && r_en_s) begin
      data_out <= src[rd_idx];
      rd_idx   <= rd_idx + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    src[src_len] = w;
    src_len++;
  endtask

  task automatic cyc;
    @(posedge rclk);
    #1;
  endtask

  task automatic samp;
    @(negedge rclk);
  endtask

  task automatic do_reset;
    r_rst_n = 1'b0;
    repeat (2) cyc();
    r_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    r_rst_n   = 1'b0;
    rd_enable = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    vec_cnt++;
    if ({r_en, out_valid, ovf_err} !== 3'b000 || out_data !== 8'h00 || pop_cnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset: r_en=%b out_valid=%b ovf_err=%b out_data=%h pop_cnt=%0d, want all 0",
               r_en, out_valid, ovf_err, out_data, pop_cnt);
    end
    repeat (2) cyc();
    r_rst_n = 1'b1;
  endtask

  task automatic test_stream;
    logic       exp_ren [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_vld [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_dat [6] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    out_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int c = 0; c < 6; c++) begin
      samp();
      vec_cnt++;
      if (r_en !== exp_ren[c] || out_valid !== exp_vld[c] || (exp_vld[c] && out_data !== exp_dat[c])) begin
        err_cnt++;
        $display("FAIL stream c%0d: r_en=%b out_valid=%b out_data=%h, want %b %b %h",
                 c, r_en, out_valid, out_data, exp_ren[c], exp_vld[c], exp_dat[c]);
      end
      cyc();
    end
    vec_cnt++;
    if (pop_cnt !== 4'd3) begin
      err_cnt++;
      $display("FAIL stream pop_cnt: got %0d want 3", pop_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic exp_ren [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_vld [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
    for (int c = 0; c < 7; c++) begin
      samp();
      vec_cnt++;
      if (r_en !== exp_ren[c] || out_valid !== exp_vld[c] || (exp_vld[c] && out_data !== 8'hB1)) begin
        err_cnt++;
        $display("FAIL backpressure c%0d: r_en=%b out_valid=%b out_data=%h, want %b %b b1",
                 c, r_en, out_valid, out_data, exp_ren[c], exp_vld[c]);
      end
      cyc();
    end
    vec_cnt++;
    if (pop_cnt !== 4'd5 || ovf_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL backpressure end: pop_cnt=%0d ovf_err=%b, want 5 0", pop_cnt, ovf_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_words [4] = '{8'hB2, 8'hB3, 8'hB4, 8'hB5};
    int idx = 0;
    out_ready = 1'b1;
    samp();
    vec_cnt++;
    if (r_en !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hB1) begin
      err_cnt++;
      $display("FAIL b2b deq+pop: r_en=%b out_valid=%b out_data=%h, want 1 1 b1", r_en, out_valid, out_data);
    end
    cyc();
    out_ready = 1'b0;
    samp();
    vec_cnt++;
    if (r_en !== 1'b0 || out_data !== 8'hB2) begin
      err_cnt++;
      $display("FAIL b2b after deq: r_en=%b out_data=%h, want 0 b2", r_en, out_data);
    end
    cyc();
    samp();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || r_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b refill: out_valid=%b out_data=%h r_en=%b, want 1 b2 0", out_valid, out_data, r_en);
    end
    cyc();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && idx < 4; n++) begin
      samp();
      if (out_valid && out_ready) begin
        vec_cnt++;
        if (out_data !== exp_words[idx]) begin
          err_cnt++;
          $display("FAIL b2b order #%0d: got %h want %h", idx, out_data, exp_words[idx]);
        end
        idx++;
      end
      cyc();
    end
    vec_cnt++;
    if (idx != 4 || pop_cnt !== 4'd8) begin
      err_cnt++;
      $display("FAIL b2b drain: words=%0d pop_cnt=%0d, want 4 8", idx, pop_cnt);
    end
  endtask

  task automatic test_flush;
    int got = 0;
    out_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (3) cyc();
    out_ready = 1'b1;
    samp();
    vec_cnt++;
    if (r_en !== 1'b1 || out_data !== 8'hC1 || pop_cnt !== 4'd10) begin
      err_cnt++;
      $display("FAIL flush setup: r_en=%b out_data=%h pop_cnt=%0d, want 1 c1 10", r_en, out_data, pop_cnt);
    end
    cyc();
    out_ready = 1'b0;
    flush     = 1'b1;
    samp();
    vec_cnt++;
    if (r_en !== 1'b0 || out_valid !== 1'b1 || pop_cnt !== 4'd11) begin
      err_cnt++;
      $display("FAIL flush cycle: r_en=%b out_valid=%b pop_cnt=%0d, want 0 1 11", r_en, out_valid, pop_cnt);
    end
    cyc();
    flush = 1'b0;
    samp();
    vec_cnt++;
    if (out_valid !== 1'b0 || pop_cnt !== 4'd11 || r_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL after flush: out_valid=%b pop_cnt=%0d r_en=%b, want 0 11 1", out_valid, pop_cnt, r_en);
    end
    cyc();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && got == 0; n++) begin
      samp();
      if (out_valid) begin
        vec_cnt++;
        if (out_data !== 8'hC4) begin
          err_cnt++;
          $display("FAIL flush drop: first word after flush %h want c4", out_data);
        end
        got = 1;
      end
      cyc();
    end
    vec_cnt++;
    if (got == 0 || pop_cnt !== 4'd12) begin
      err_cnt++;
      $display("FAIL flush drain: got=%0d pop_cnt=%0d, want 1 12", got, pop_cnt);
    end
  endtask

  task automatic test_rd_enable;
    logic exp_ren [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_vld [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int got = 0;
    rd_enable = 1'b0;
    out_ready = 1'b1;
    push(8'hD1); push(8'hD2);
    for (int c = 0; c < 6; c++) begin
      rd_enable = (c == 2);
      samp();
      vec_cnt++;
      if (r_en !== exp_ren[c] || out_valid !== exp_vld[c] || (exp_vld[c] && out_data !== 8'hD1)) begin
        err_cnt++;
        $display("FAIL rd_enable c%0d: r_en=%b out_valid=%b out_data=%h, want %b %b d1",
                 c, r_en, out_valid, out_data, exp_ren[c], exp_vld[c]);
      end
      cyc();
    end
    rd_enable = 1'b1;
    for (int n = 0; n < 10 && got == 0; n++) begin
      samp();
      if (out_valid) begin
        vec_cnt++;
        if (out_data !== 8'hD2) begin
          err_cnt++;
          $display("FAIL rd_enable resume: got %h want d2", out_data);
        end
        got = 1;
      end
      cyc();
    end
    vec_cnt++;
    if (got == 0 || pop_cnt !== 4'd14) begin
      err_cnt++;
      $display("FAIL rd_enable end: got=%0d pop_cnt=%0d, want 1 14", got, pop_cnt);
    end
  endtask

  task automatic test_cnt_wrap;
    int idx = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) push(8'h40 + 8'(i));
    for (int n = 0; n < 40 && idx < 15; n++) begin
      samp();
      if (out_valid) begin
        vec_cnt++;
        if (out_data !== 8'h40 + 8'(idx)) begin
          err_cnt++;
          $display("FAIL wrap order #%0d: got %h want %h", idx, out_data, 8'h40 + 8'(idx));
        end
        idx++;
      end
      cyc();
    end
    vec_cnt++;
    if (idx != 15 || pop_cnt !== 4'd15) begin
      err_cnt++;
      $display("FAIL wrap 15 pops: words=%0d pop_cnt=%0d, want 15 15", idx, pop_cnt);
    end
    push(8'h5F);
    samp();
    vec_cnt++;
    if (r_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap 16th pop: r_en=%b want 1", r_en);
    end
    repeat (4) cyc();
    vec_cnt++;
    if (pop_cnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL wrap: pop_cnt=%0d want 0", pop_cnt);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    repeat (3) cyc();
    samp();
    vec_cnt++;
    if (out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL async setup: out_valid=%b want 1", out_valid);
    end
    cyc();
    #2;
    r_rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({r_en, out_valid, ovf_err} !== 3'b000 || out_data !== 8'h00 || pop_cnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL async reset: r_en=%b out_valid=%b ovf_err=%b out_data=%h pop_cnt=%0d, want all 0",
               r_en, out_valid, ovf_err, out_data, pop_cnt);
    end
    cyc();
    r_rst_n = 1'b1;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL async release: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rd_enable();
    test_cnt_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
